// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: received byte plus its status pulses.
interface uart_rx_if;
   logic [7:0] dout_o;
   logic       rx_done_tick_o;
   logic       frame_err_o;

   modport master (
      output dout_o,
      output rx_done_tick_o,
      output frame_err_o
   );

   modport slave (
      input dout_o,
      input rx_done_tick_o,
      input frame_err_o
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with mid-bit sampling.
// Optional feature macro: UART_RX_FRAME_ERR_EN (stop-bit check and frame_err_o pulse).
module uart_rx #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic      clk,
   input  logic      rst_i,
   input  logic      rx_i,
   uart_rx_if.master bus
);

   localparam int unsigned BitTicks  = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned HalfTicks = BitTicks / 2;
   localparam int unsigned CntW      = $clog2(BitTicks);
   localparam logic [CntW-1:0] BitLast  = CntW'(BitTicks - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(HalfTicks - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      sreg_q, sreg_d;
   logic [7:0]      dout_q, dout_d;
   logic            done_q, done_d;
   logic            seen_q, seen_d;
   logic            rxs;

   assign rxs = sync_q[1];

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

`ifdef UART_RX_FRAME_ERR_EN
   logic ferr_q, ferr_d;

   // Registered framing-error pulse.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         ferr_q <= 1'b0;
      end else begin
         ferr_q <= ferr_d;
      end
   end

   assign bus.frame_err_o = ferr_q;
`else
   assign bus.frame_err_o = 1'b0;
`endif

   // FSM state, bit counter, shift register and output registers.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         sreg_q  <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         seen_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sreg_q  <= sreg_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         seen_q  <= seen_d;
      end
   end

   // Next-state logic; the counter is cleared whenever a sample point is reached.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      sreg_d  = sreg_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      seen_d  = seen_q;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_d  = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            // A held-low line after a stop sample must go high before a new start counts.
            if (rxs) begin
               seen_d = 1'b1;
            end else if (seen_q) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (rxs) begin
                  state_d = StIdle;
               end else begin
                  state_d = StData;
                  idx_d   = '0;
               end
            end
         end
         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d  = '0;
               sreg_d = {rxs, sreg_q[7:1]};
               idx_d  = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            if (cnt_q == BitLast) begin
               cnt_d   = '0;
               state_d = StIdle;
               seen_d  = rxs;
`ifdef UART_RX_FRAME_ERR_EN
               if (rxs) begin
                  dout_d = sreg_q;
                  done_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
`else
               dout_d = sreg_q;
               done_d = 1'b1;
`endif
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.dout_o         = dout_q;
   assign bus.rx_done_tick_o = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a negedge monitor checks them.
module tb_uart_rx;

`ifdef UART_RX_FRAME_ERR_EN
   localparam bit FerrEn = 1'b1;
`else
   localparam bit FerrEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic rx2 = 1'b1;

   uart_rx_if bus1 ();
   uart_rx_if bus2 ();

   // Test-plan instance: 10 cycles per bit.
   uart_rx #(
      .CLOCK_FREQ(1_000_000),
      .BAUD_RATE (100_000)
   ) dut (
      .clk  (clk),
      .rst_i(rst),
      .rx_i (rx),
      .bus  (bus1)
   );

   // Default-parameter instance for the loopback-style check (434 ticks per bit).
   uart_rx dut2 (
      .clk  (clk),
      .rst_i(rst),
      .rx_i (rx2),
      .bus  (bus2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         which;
      bit         is_err;
      logic [7:0] data;
      int         exp_cyc;
   } evt_t;

   evt_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int w, input logic done, input logic err, input logic [7:0] d);
      evt_t e;
      if (done === 1'b1 || err === 1'b1) begin
         check("pulse_exclusive", {31'd0, done & err}, 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: inst %0d done=%b err=%b dout=%0h, expected none",
                     w, done, err, d);
         end else begin
            e = sb.pop_front();
            check("evt_source", w, e.which);
            check("evt_kind", {31'd0, err}, {31'd0, e.is_err});
            if (!e.is_err) check("dout_at_done", {24'd0, d}, {24'd0, e.data});
            if (e.exp_cyc >= 0) check("done_latency", cyc, e.exp_cyc);
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from register updates.
   always @(negedge clk) begin
      mon(0, bus1.rx_done_tick_o, bus1.frame_err_o, bus1.dout_o);
      mon(1, bus2.rx_done_tick_o, bus2.frame_err_o, bus2.dout_o);
   end

   task automatic set_line(input int w, input logic v);
      if (w == 0) rx = v;
      else rx2 = v;
   endtask

   task automatic drive_bit(input int w, input logic v, input int per);
      @(posedge clk);
      #1;
      set_line(w, v);
      repeat (per - 1) @(posedge clk);
   endtask

   // One frame; the expected event is queued as soon as the start bit goes out.
   task automatic send_frame(input int w, input logic [7:0] d, input int per, input bit stop_v,
                             input bit timed);
      evt_t e;
      @(posedge clk);
      #1;
      set_line(w, 1'b0);
      e.which   = w;
      e.is_err  = FerrEn && !stop_v;
      e.data    = d;
      // Start edge lands in cycle cyc; t0 = cyc+2; done high in t0+96.
      e.exp_cyc = timed ? cyc + 98 : -1;
      sb.push_back(e);
      repeat (per - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(w, d[i], per);
      drive_bit(w, stop_v, per);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      logic [7:0] lb [4];
      logic [7:0] ab;
      lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF;
      ab = 8'h5A;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout", {24'd0, bus1.dout_o}, 32'h00);
      check("rst_done", {31'd0, bus1.rx_done_tick_o}, 32'd0);
      check("rst_ferr", {31'd0, bus1.frame_err_o}, 32'd0);
      check("rst_dout2", {24'd0, bus2.dout_o}, 32'h00);
      rst = 1'b0;
      idle(5);

      // Single frame with exact latency.
      send_frame(0, 8'hA5, 10, 1'b1, 1'b1);
      idle(20);
      check("single_dout", {24'd0, bus1.dout_o}, 32'hA5);

      // Back-to-back, no idle gap.
      send_frame(0, 8'h00, 10, 1'b1, 1'b0);
      send_frame(0, 8'hFF, 10, 1'b1, 1'b0);
      idle(20);
      check("b2b_dout", {24'd0, bus1.dout_o}, 32'hFF);

      // Glitch: 3 low cycles is a false start.
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      idle(30);
      check("glitch_dout", {24'd0, bus1.dout_o}, 32'hFF);
      check("glitch_no_evt", sb.size(), 32'd0);

      // Stop bit low, line held low (break) before returning high.
      send_frame(0, 8'h3C, 10, 1'b0, 1'b0);
      idle(30);
      #1 rx = 1'b1;
      idle(30);
      check("ferr_dout", {24'd0, bus1.dout_o}, FerrEn ? 32'hFF : 32'h3C);

      // Reset during data bit 4.
      drive_bit(0, 1'b0, 10);
      for (int i = 0; i < 4; i++) drive_bit(0, ab[i], 10);
      @(posedge clk);
      #1 rx = ab[4];
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx  = 1'b1;
      check("midrst_dout", {24'd0, bus1.dout_o}, 32'h00);
      check("midrst_done", {31'd0, bus1.rx_done_tick_o}, 32'd0);
      check("midrst_ferr", {31'd0, bus1.frame_err_o}, 32'd0);
      idle(40);
      check("midrst_no_evt", sb.size(), 32'd0);
      send_frame(0, 8'h81, 10, 1'b1, 1'b0);
      idle(20);
      check("post_rst_dout", {24'd0, bus1.dout_o}, 32'h81);

      // Transmitter-rate frames (BIT_TICKS+1 cycles per bit) at default parameters.
      for (int i = 0; i < 4; i++) send_frame(1, lb[i], 435, 1'b1, 1'b0);
      idle(300);

      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
      check("sb_drained", sb.size(), 32'd0);
      check("loop_last_dout", {24'd0, bus2.dout_o}, 32'hFF);
      check("inst1_dout_final", {24'd0, bus1.dout_o}, 32'h81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver. Deserializes 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from the line driven by the team's `uart_tx` into bytes. It sits at the host-link input of the AES test design, feeding plaintext/key bytes to the encryption/decryption datapath. Each byte is presented on `dout_o` together with a one-cycle `rx_done_tick_o` pulse.

## Interface
- `CLOCK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line bit rate in baud.
- Derived constants:
  - `BIT_TICKS` = CLOCK_FREQ/BAUD_RATE (integer division); 434 at the defaults.
  - `HALF_TICKS` = BIT_TICKS/2 (floor).
  - BIT_TICKS ≥ 4 is required.
- `clk`  in  1  system clock; all logic acts on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rx_i`  in  1  serial line, asynchronous to `clk`; idle level is 1.
- `dout_o`  out  8  last correctly received byte.
- `rx_done_tick_o`  out  1  one-cycle pulse; a new byte is on `dout_o`.
- `frame_err_o`  out  1  one-cycle pulse; stop bit sampled low (see Configuration).

## Operation
- `rx_i` always passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- A single counter counts clock cycles within a bit. It is cleared on every state transition.
- States:
  - S_IDLE:
    - Counter held at 0.
    - Moves to S_START on the first cycle with `rxs`=0. Call that cycle t0.
  - S_START:
    - Counts to HALF_TICKS.
    - At t0+HALF_TICKS, samples `rxs`. If 1: false start, return to S_IDLE with no outputs. If 0: clear counter and bit index, go to S_DATA.
  - S_DATA:
    - Every BIT_TICKS cycles, samples `rxs` into the shift register at the MSB end and shifts right, so the first bit received ends in bit 0.
    - Bit index 0..7. Sample of bit k occurs at t0+HALF_TICKS+(k+1)·BIT_TICKS.
    - After bit 7, go to S_STOP.
  - S_STOP:
    - Samples `rxs` at t0+HALF_TICKS+9·BIT_TICKS.
    - If 1: load `dout_o` from the shift register and pulse `rx_done_tick_o` on the next cycle, then go to S_IDLE.
    - If 0: behaviour per Configuration.
- `dout_o` holds its value until the next successful frame. It never changes while a frame is in progress.
- Line stuck low after a frame (break):
  - No false re-trigger. S_IDLE requires `rxs` to have been seen at 1 at least once after a stop sample before it accepts a new falling edge.
  - Edge detection is done on `rxs` level in S_IDLE, gated by this "seen high" flag.
- Back-to-back frames: a start bit that immediately follows the stop bit is detected and received correctly. The receiver is back in S_IDLE before the transmitter's stop bit ends.

## Timing
- Reset values:
  - `dout_o`=8'h00, `rx_done_tick_o`=0, `frame_err_o`=0.
  - State S_IDLE, counter 0, synchronizer flops 1, seen-high flag 1.
- `rst_i` asserted in any state returns to these values on the next edge. A partial frame is discarded; no pulse is issued.
- Latency:
  - `rx_done_tick_o` is high exactly during cycle t0+HALF_TICKS+9·BIT_TICKS+1.
  - t0 lags the line edge on `rx_i` by 2 cycles (synchronizer).
- `rx_done_tick_o` and `frame_err_o` are registered. They are never high at the same time and never high for more than 1 cycle per frame.
- Sampling tolerance: mid-bit sampling accepts a transmitter bit period of BIT_TICKS±BIT_TICKS/20 cycles. This covers `uart_tx` at equal parameters, which runs at BIT_TICKS+1 cycles per bit.

## Configuration
- `UART_RX_FRAME_ERR_EN` defined:
  - A low stop-bit sample pulses `frame_err_o` for one cycle, one cycle after the sample.
  - No `rx_done_tick_o` is issued and `dout_o` is left unchanged.
  - The FSM returns to S_IDLE with the seen-high flag cleared.
- `UART_RX_FRAME_ERR_EN` undefined:
  - The stop bit is not checked. `dout_o` is loaded and `rx_done_tick_o` pulses regardless of the stop sample.
  - `frame_err_o` is tied to 0.

## Test plan
All scenarios use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, giving BIT_TICKS=10 and HALF_TICKS=5, unless stated otherwise.
- Single frame: drive 0xA5 at 10 cycles/bit -> `dout_o`=0xA5, one `rx_done_tick_o` pulse at t0+96, no `frame_err_o`.
- Back-to-back: 0x00 then 0xFF with 1 stop bit and no idle gap -> two pulses, `dout_o`=0x00 then 0xFF.
- Glitch: `rx_i` low for 3 cycles, then high -> returns to S_IDLE, no pulses, `dout_o` unchanged.
- Framing error: frame 0x3C with stop bit low, then line high.
  - With the macro: one `frame_err_o` pulse, no done pulse, `dout_o` keeps its previous value.
  - Without the macro: done pulse with `dout_o`=0x3C.
- Reset mid-frame: assert `rst_i` for 1 cycle during data bit 4 -> all outputs at reset values, no pulse. The next frame 0x81 is received as 0x81.
- Loopback with `uart_tx` at default parameters: bytes 0x00, 0x55, 0xAA, 0xFF -> all four received in order, zero errors.
